ysyx_25060170_regfile: RTL

Architectural integer register file for the 5-stage RV32 core. It is the responder for the decode-stage read interface: two enabled read ports, rs1 and rs2. It accepts one write per cycle from the write-back stage. Same-cycle write-to-read bypass is internal, so decode sees a WB result in the cycle it is written. It also provides a registered debug/difftest read port and a write-retire counter.

---
 rtl/ysyx_25060170_regfile_if.sv | 29 ++
 rtl/ysyx_25060170_regfile.sv | 81 ++++++++
 2 files changed

// File: rtl/ysyx_25060170_regfile_if.sv
// Decode-read and write-back bundle for the register file; decode/WB side is
// the master, the register file is the slave.
interface ysyx_25060170_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs1_addr;
  logic              rs1_ena;
  logic [DATA_W-1:0] rs1_data;
  logic [ADDR_W-1:0] rs2_addr;
  logic              rs2_ena;
  logic [DATA_W-1:0] rs2_data;
  logic              wb_valid;
  logic              wb_rd_ena;
  logic [ADDR_W-1:0] wb_rd_addr;
  logic [DATA_W-1:0] wb_rd_data;

  modport master (
    output rs1_addr, rs1_ena, rs2_addr, rs2_ena,
    output wb_valid, wb_rd_ena, wb_rd_addr, wb_rd_data,
    input  rs1_data, rs2_data
  );

  modport slave (
    input  rs1_addr, rs1_ena, rs2_addr, rs2_ena,
    input  wb_valid, wb_rd_ena, wb_rd_addr, wb_rd_data,
    output rs1_data, rs2_data
  );
endinterface

// File: rtl/ysyx_25060170_regfile.sv
// RV32 architectural register file: two combinational read ports with
// write-first bypass, one write port, registered debug read, write counter.
module ysyx_25060170_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_25060170_regfile_if.slave rf,
  input  logic [ADDR_W-1:0]      dbg_addr,
  output logic [DATA_W-1:0]      dbg_data,
  output logic [CNT_W-1:0]       wr_cnt
);
  localparam int NREG = 2 ** ADDR_W;

  // x0 has no storage; every access to it is intercepted before indexing.
  logic [DATA_W-1:0] regs_q [1:NREG-1];
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              we;

  assign we = rf.wb_valid & rf.wb_rd_ena & (rf.wb_rd_addr != '0);

  always_comb begin
    rf.rs1_data = '0;
    if (rst && rf.rs1_ena && (rf.rs1_addr != '0)) begin
      if (we && (rf.wb_rd_addr == rf.rs1_addr)) begin
        rf.rs1_data = rf.wb_rd_data;
      end else begin
        rf.rs1_data = regs_q[rf.rs1_addr];
      end
    end
  end

  always_comb begin
    rf.rs2_data = '0;
    if (rst && rf.rs2_ena && (rf.rs2_addr != '0)) begin
      if (we && (rf.wb_rd_addr == rf.rs2_addr)) begin
        rf.rs2_data = rf.wb_rd_data;
      end else begin
        rf.rs2_data = regs_q[rf.rs2_addr];
      end
    end
  end

  // Debug sample sees the post-write value, so a same-cycle write shows up.
  always_comb begin
    dbg_data_d = '0;
    wr_cnt_d   = wr_cnt_q;
    if (dbg_addr != '0) begin
      if (we && (rf.wb_rd_addr == dbg_addr)) begin
        dbg_data_d = rf.wb_rd_data;
      end else begin
        dbg_data_d = regs_q[dbg_addr];
      end
    end
    if (we) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      dbg_data_q <= '0;
      wr_cnt_q   <= '0;
    end else begin
      if (we) begin
        regs_q[rf.wb_rd_addr] <= rf.wb_rd_data;
      end
      dbg_data_q <= dbg_data_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign dbg_data = dbg_data_q;
  assign wr_cnt   = wr_cnt_q;
endmodule
